reg_file_mp: RTL and testbench
==============================

Name: reg_file_mp

Overview:
Parametrised multi-port integer register file with a per-register busy/tag scoreboard, intended for a dual-issue or out-of-order core.
- Generalises the single-write/dual-read regfile to NUM_RD read ports and NUM_WR write ports.
- Keeps x0 hard-wired to zero and forwards same-cycle writes to reads.
- Adds a scoreboard: issue marks a destination busy with a producer tag; writeback with a matching tag clears it.
- Sits between decode/issue (reads, issue marking) and writeback (write ports).

Parameters:
DATA_W, 32, register width
ADDR_W, 5, register address width; register count = 2**ADDR_W
NUM_RD, 2, number of read ports
NUM_WR, 2, number of write ports
TAG_W, 4, producer tag width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
rd_en  in  NUM_RD  per-port read enable
rd_addr  in  NUM_RD*ADDR_W  read addresses, port i at [i*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  read data, packed the same way
rd_busy  out  NUM_RD  source register still pending
rd_tag  out  NUM_RD*TAG_W  pending producer tag (valid when rd_busy)
wr_en  in  NUM_WR  per-port write enable
wr_addr  in  NUM_WR*ADDR_W  write addresses
wr_data  in  NUM_WR*DATA_W  write data
wr_tag  in  NUM_WR*TAG_W  tag of the producing instruction
iss_en  in  1  mark a destination register busy
iss_addr  in  ADDR_W  destination being issued
iss_tag  in  TAG_W  tag assigned to that destination
flush  in  1  synchronous clear of all busy bits

Behaviour:
- Reset (rst=0, asynchronous):
  - all registers, busy bits and tags go to 0 immediately;
  - rd_data, rd_busy and rd_tag are forced to 0 while rst=0, regardless of other inputs.
  - Reset asserted mid-operation discards any write or issue in that cycle.
- Write, at posedge clk:
  - Each port with wr_en=1 and wr_addr!=0 writes regs[wr_addr] <= wr_data.
  - Two or more ports writing the same address: the highest port index wins.
  - Writes to address 0 are ignored.
- Busy clear: a write port clears busy[a] if busy[a]=1 and wr_tag == tag[a].
  - A tag mismatch writes the data but leaves busy and tag unchanged (stale producer).
- Issue: iss_en=1 and iss_addr!=0 sets busy[iss_addr]=1 and tag[iss_addr]=iss_tag at the next edge.
  - Issue beats a same-cycle clear or flush on the same register.
  - iss_addr=0 is ignored.
- Flush: flush=1 clears every busy bit at the edge, except a same-cycle issue, which still sets its register. Register data is untouched.
- Read, combinational with zero latency, per port i:
  - rd_en=0 or rd_addr=0 -> data 0, busy 0, tag 0.
  - Otherwise, if any write port has wr_en=1 and the same address, data = that wr_data (highest index wins). rd_busy = busy & ~(the winning write's tag == stored tag). Only the winning (highest-index) write port is evaluated, so this mirrors the next-state busy bit.
  - Otherwise, data = regs[addr], rd_busy = busy[addr], rd_tag = tag[addr].
  - A same-cycle issue is not visible to reads; reads see pre-issue state.
  - A same-cycle flush is not visible to reads.
- There are no handshakes and no stalls: every port accepts every cycle.

Decomposition:
- Shared package/define file holds the defaults: DATA_W, ADDR_W, TAG_W, register count, and the zero-register index constant.
- One sub-module is natural: reg_file_rd_port (single read port with bypass mux and busy/tag logic), instantiated NUM_RD times via generate.
- Storage, write arbitration and scoreboard stay in the top module.

Test Plan:
- Reset: hold rst=0 with rd_en=1 and rd_addr=3 -> rd_data=0, rd_busy=0. Release rst, read all 32 registers -> all 0.
- Bypass and priority: same cycle, wr0 (addr 5, 0xAAAA) and wr1 (addr 5, 0x5555), rd port 0 addr 5 -> rd_data=0x5555 that cycle; next cycle, regs[5]=0x5555.
- x0: wr_en=1, addr 0, data 0xFFFFFFFF; iss_en addr 0 -> reading addr 0 gives data 0, busy 0 forever.
- Scoreboard: issue addr 7 tag 3 -> next cycle rd_busy=1, rd_tag=3. Write addr 7 tag 2 -> data updated, busy stays 1. Write addr 7 tag 3 -> same-cycle rd_busy=0, and busy stays 0 after the edge.
- Issue vs clear: same cycle, write addr 9 with matching tag 1 and issue addr 9 tag 4 -> after the edge busy=1, tag=4.
- Flush: registers 2, 4, 6 busy; flush=1 with iss addr 4 tag 8 -> after the edge only reg 4 is busy (tag 8), and data is unchanged. Assert rst low mid-sequence -> busy clears immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/reg_file_mp_pkg.sv
// reg_file_mp_pkg: shared defaults for the multi-port register file
package reg_file_mp_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int TAG_W_DEF = 4;
  localparam int NUM_RD_DEF = 2;
  localparam int NUM_WR_DEF = 2;
  localparam int NUM_REGS_DEF = 2 ** ADDR_W_DEF;
  localparam int ZERO_REG = 0;
endpackage

// File: rtl/reg_file_rd_port.sv
// reg_file_rd_port: one read port with write bypass and scoreboard view
module reg_file_rd_port
  import reg_file_mp_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int TAG_W = TAG_W_DEF,
  parameter int NUM_WR = NUM_WR_DEF
) (
  input  logic                     rst,
  input  logic                     en,
  input  logic [ADDR_W-1:0]        addr,
  input  logic [DATA_W-1:0]        st_data,
  input  logic                     st_busy,
  input  logic [TAG_W-1:0]         st_tag,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic [NUM_WR*TAG_W-1:0]  wr_tag,
  output logic [DATA_W-1:0]        data,
  output logic                     busy,
  output logic [TAG_W-1:0]         tag
);
  logic              hit, valid;
  logic [DATA_W-1:0] hit_data;
  logic [TAG_W-1:0]  hit_tag;
  // highest-index matching write wins the bypass; outputs are zero in reset
  always_comb begin
    hit = 1'b0;
    hit_data = '0;
    hit_tag = '0;
    for (int p = 0; p < NUM_WR; p++)
      if (wr_en[p] && wr_addr[p*ADDR_W +: ADDR_W] == addr) begin
        hit = 1'b1;
        hit_data = wr_data[p*DATA_W +: DATA_W];
        hit_tag = wr_tag[p*TAG_W +: TAG_W];
      end
    valid = rst && en && addr != ADDR_W'(ZERO_REG);
    data = !valid ? '0 : hit ? hit_data : st_data;
    busy = valid && st_busy && !(hit && hit_tag == st_tag);
    tag = valid ? st_tag : '0;
  end
endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port register file with busy/tag scoreboard
module reg_file_mp
  import reg_file_mp_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = NUM_RD_DEF,
  parameter int NUM_WR = NUM_WR_DEF,
  parameter int TAG_W = TAG_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  output logic [NUM_RD*TAG_W-1:0]  rd_tag,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic [NUM_WR*TAG_W-1:0]  wr_tag,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  input  logic [TAG_W-1:0]         iss_tag,
  input  logic                     flush
);
  localparam int NREG = 2 ** ADDR_W;
  logic [DATA_W-1:0] regs [NREG];
  logic [TAG_W-1:0]  tags [NREG];
  logic [NREG-1:0]   busy;
  logic [NREG-1:0]   wv;
  logic [DATA_W-1:0] wd [NREG];
  logic [TAG_W-1:0]  wt [NREG];
  // per-register winning write (highest port index)
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      wv[r] = 1'b0;
      wd[r] = '0;
      wt[r] = '0;
      for (int p = 0; p < NUM_WR; p++)
        if (wr_en[p] && wr_addr[p*ADDR_W +: ADDR_W] == ADDR_W'(r)) begin
          wv[r] = 1'b1;
          wd[r] = wr_data[p*DATA_W +: DATA_W];
          wt[r] = wr_tag[p*TAG_W +: TAG_W];
        end
    end
  end
  // storage and scoreboard: issue beats flush beats tag-matched clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= '0;
      for (int r = 0; r < NREG; r++) begin
        regs[r] <= '0;
        tags[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NREG; r++)
        if (r != ZERO_REG) begin
          if (wv[r]) regs[r] <= wd[r];
          if (iss_en && iss_addr == ADDR_W'(r)) begin
            busy[r] <= 1'b1;
            tags[r] <= iss_tag;
          end else if (flush || (wv[r] && busy[r] && wt[r] == tags[r]))
            busy[r] <= 1'b0;
        end
    end
  end
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] a;
    assign a = rd_addr[i*ADDR_W +: ADDR_W];
    reg_file_rd_port #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .TAG_W(TAG_W), .NUM_WR(NUM_WR)
    ) u_rd (
      .rst(rst),
      .en(rd_en[i]),
      .addr(a),
      .st_data(regs[a]),
      .st_busy(busy[a]),
      .st_tag(tags[a]),
      .wr_en(wr_en),
      .wr_addr(wr_addr),
      .wr_data(wr_data),
      .wr_tag(wr_tag),
      .data(rd_data[i*DATA_W +: DATA_W]),
      .busy(rd_busy[i]),
      .tag(rd_tag[i*TAG_W +: TAG_W])
    );
  end
endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: directed self-checking bench for reg_file_mp
module tb_reg_file_mp;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  rd_en = '0;
  logic [9:0]  rd_addr = '0;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic [7:0]  rd_tag;
  logic [1:0]  wr_en = '0;
  logic [9:0]  wr_addr = '0;
  logic [63:0] wr_data = '0;
  logic [7:0]  wr_tag = '0;
  logic        iss_en = 1'b0;
  logic [4:0]  iss_addr = '0;
  logic [3:0]  iss_tag = '0;
  logic        flush = 1'b0;
  int checks = 0;
  int errors = 0;

  reg_file_mp dut (
    .clk(clk), .rst(rst),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy), .rd_tag(rd_tag),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_tag(wr_tag),
    .iss_en(iss_en), .iss_addr(iss_addr), .iss_tag(iss_tag), .flush(flush)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic rd(input int p, input logic [4:0] a);
    rd_en[p] = 1'b1;
    rd_addr[p*5 +: 5] = a;
  endtask

  task automatic wr(input int p, input logic [4:0] a, input logic [31:0] d, input logic [3:0] t);
    wr_en[p] = 1'b1;
    wr_addr[p*5 +: 5] = a;
    wr_data[p*32 +: 32] = d;
    wr_tag[p*4 +: 4] = t;
  endtask

  task automatic iss(input logic [4:0] a, input logic [3:0] t);
    iss_en = 1'b1;
    iss_addr = a;
    iss_tag = t;
  endtask

  task automatic idle();
    wr_en = '0;
    iss_en = 1'b0;
    flush = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  function automatic logic [31:0] dat(input int p);
    return rd_data[p*32 +: 32];
  endfunction

  function automatic logic [31:0] tg(input int p);
    return {28'd0, rd_tag[p*4 +: 4]};
  endfunction

  function automatic logic [31:0] bz(input int p);
    return {31'd0, rd_busy[p]};
  endfunction

  initial begin
    // reset held: outputs forced to zero even with a bypassing write
    rd(0, 5'd3);
    wr(0, 5'd3, 32'hDEAD_BEEF, 4'd0);
    iss(5'd3, 4'd1);
    #3;
    chk("rst_data", dat(0), 32'h0);
    chk("rst_busy", bz(0), 32'h0);
    @(posedge clk);
    #1;
    chk("rst_hold_data", dat(0), 32'h0);
    idle();
    rst = 1'b1;
    #1;
    for (int a = 0; a < 32; a++) begin
      rd(0, 5'(a));
      rd(1, 5'(a));
      #1;
      chk($sformatf("init_r%0d_p0", a), dat(0), 32'h0);
      chk($sformatf("init_r%0d_p1", a), dat(1), 32'h0);
    end
    // bypass with port priority
    tick();
    wr(0, 5'd5, 32'h0000_AAAA, 4'd0);
    wr(1, 5'd5, 32'h0000_5555, 4'd0);
    rd(0, 5'd5);
    rd(1, 5'd5);
    #1;
    chk("byp_p0", dat(0), 32'h5555);
    chk("byp_p1", dat(1), 32'h5555);
    tick();
    #1;
    chk("prio_stored", dat(0), 32'h5555);
    // x0 stays zero and never busy
    wr(0, 5'd0, 32'hFFFF_FFFF, 4'd5);
    iss(5'd0, 4'd5);
    rd(0, 5'd0);
    #1;
    chk("x0_byp_data", dat(0), 32'h0);
    chk("x0_byp_busy", bz(0), 32'h0);
    tick();
    #1;
    chk("x0_data", dat(0), 32'h0);
    chk("x0_busy", bz(0), 32'h0);
    // rd_en low blanks the port
    rd_en[1] = 1'b0;
    rd_addr[9:5] = 5'd5;
    #1;
    chk("rden_off", dat(1), 32'h0);
    // scoreboard issue / stale write / matching write
    iss(5'd7, 4'd3);
    rd(0, 5'd7);
    #1;
    chk("iss_invisible", bz(0), 32'h0);
    tick();
    #1;
    chk("iss_busy", bz(0), 32'h1);
    chk("iss_tag", tg(0), 32'h3);
    wr(0, 5'd7, 32'h1234, 4'd2);
    #1;
    chk("stale_byp_data", dat(0), 32'h1234);
    chk("stale_byp_busy", bz(0), 32'h1);
    tick();
    #1;
    chk("stale_data", dat(0), 32'h1234);
    chk("stale_busy", bz(0), 32'h1);
    chk("stale_tag", tg(0), 32'h3);
    wr(1, 5'd7, 32'h77, 4'd3);
    #1;
    chk("clr_byp_busy", bz(0), 32'h0);
    chk("clr_byp_data", dat(0), 32'h77);
    tick();
    #1;
    chk("clr_busy", bz(0), 32'h0);
    chk("clr_data", dat(0), 32'h77);
    // issue beats same-cycle matching clear
    iss(5'd9, 4'd1);
    tick();
    wr(0, 5'd9, 32'h9, 4'd1);
    iss(5'd9, 4'd4);
    rd(0, 5'd9);
    #1;
    chk("ivc_byp_busy", bz(0), 32'h0);
    tick();
    #1;
    chk("ivc_busy", bz(0), 32'h1);
    chk("ivc_tag", tg(0), 32'h4);
    chk("ivc_data", dat(0), 32'h9);
    // only the winning write port decides the clear
    wr(0, 5'd9, 32'hA, 4'd4);
    wr(1, 5'd9, 32'hB, 4'd2);
    #1;
    chk("win_byp_busy", bz(0), 32'h1);
    tick();
    #1;
    chk("win_busy", bz(0), 32'h1);
    chk("win_data", dat(0), 32'hB);
    // flush keeps only the same-cycle issue
    wr(0, 5'd4, 32'hBEEF, 4'd0);
    iss(5'd2, 4'd1);
    tick();
    iss(5'd4, 4'd2);
    tick();
    iss(5'd6, 4'd3);
    tick();
    flush = 1'b1;
    iss(5'd4, 4'd8);
    rd(0, 5'd2);
    #1;
    chk("flush_invisible", bz(0), 32'h1);
    tick();
    rd(1, 5'd4);
    #1;
    chk("flush_r2", bz(0), 32'h0);
    chk("flush_r4_busy", bz(1), 32'h1);
    chk("flush_r4_tag", tg(1), 32'h8);
    chk("flush_r4_data", dat(1), 32'hBEEF);
    rd(0, 5'd6);
    #1;
    chk("flush_r6", bz(0), 32'h0);
    // asynchronous reset mid-sequence, released before any edge
    rd(0, 5'd5);
    #1;
    chk("pre_rst_data", dat(0), 32'h5555);
    rst = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    chk("arst_r4_busy", bz(1), 32'h0);
    chk("arst_r4_data", dat(1), 32'h0);
    chk("arst_r5_data", dat(0), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
